fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 121 ++++++++++++
 tb/tb_fetch_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch FSM feeding a small in-order queue
// toward decode. Branch redirects flush the queue and restart fetch.
// Optional macro FETCH_PREFETCH_EN selects queue depth 2 (default depth 1).
module fetch_controller (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

`ifdef FETCH_PREFETCH_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] instr_q [DEPTH];
    logic [31:0] instr_d [DEPTH];
    logic [31:0] pcn_q   [DEPTH];
    logic [31:0] pcn_d   [DEPTH];

    logic        full;
    logic        push;
    logic        pop;
    logic [1:0]  cnt_pop;

    // Handshake qualification and output decode; a branch overrides any push or pop.
    always_comb begin
        full     = (cnt_q == DEPTH_CNT);
        id_valid = (cnt_q != '0);
        pop      = id_valid && id_ready && !branch_taken;
        push     = (state_q == S_REQ) && mem_ack && !full && !branch_taken;
        mem_req  = (state_q == S_REQ);
        mem_addr = pc_q;
        id_instr = id_valid ? instr_q[0] : '0;
        id_pc    = id_valid ? pcn_q[0]   : '0;
    end

    // Next-state logic: fetch until the queue fills, wait in HOLD until decode drains.
    always_comb begin
        state_d = state_q;
        if (branch_taken) begin
            state_d = S_REQ;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_REQ;
                S_REQ:   if (push && !pop && (cnt_q + 2'd1 == DEPTH_CNT)) state_d = S_HOLD;
                S_HOLD:  if (pop) state_d = S_REQ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Queue and pc update: head is entry 0, pop shifts down, push lands after the survivors.
    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        pcn_d   = pcn_q;
        cnt_pop = pop ? (cnt_q - 2'd1) : cnt_q;
        if (branch_taken) begin
            pc_d  = branch_addr & ~32'd3;
            cnt_d = '0;
        end else begin
            if (pop) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    instr_d[i] = instr_q[i + 1];
                    pcn_d[i]   = pcn_q[i + 1];
                end
            end
            if (push) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (cnt_pop == 2'(i)) begin
                        instr_d[i] = mem_rdata;
                        pcn_d[i]   = pc_q + 32'd4;
                    end
                end
                pc_d = pc_q + 32'd4;
            end
            cnt_d = cnt_pop + (push ? 2'd1 : 2'd0);
        end
    end

    // State, pc and queue registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pcn_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            pcn_q   <= pcn_d;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed testbench for fetch_controller; expectations follow the queue
// depth selected by FETCH_PREFETCH_EN.
module tb_fetch_controller;

    localparam logic [31:0] KEY = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    int checks = 0;
    int errors = 0;

    fetch_controller dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .id_ready     (id_ready),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc        (id_pc)
    );

    always #5 clk = ~clk;

    // Memory model: the word at an address is the address XOR a fixed key.
    assign mem_rdata = mem_addr ^ KEY;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, mem_req}, {31'd0, req});
        chk({tag, "_addr"}, mem_addr, addr);
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        chk({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
        chk({tag, "_pc"}, id_pc, pc);
        chk({tag, "_instr"}, id_instr, instr);
    endtask

    task automatic chk_zero(input string tag);
        chk_fetch(tag, 1'b0, 32'd0);
        chk({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
        chk({tag, "_pc"}, id_pc, 32'd0);
        chk({tag, "_instr"}, id_instr, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; mem_ack = 1'b0; branch_taken = 1'b0; branch_addr = '0; id_ready = 1'b0;
        step(); step();
        chk_zero("reset");

        // Streaming with ack and ready tied high
        mem_ack = 1'b1; id_ready = 1'b1; rst = 1'b1;
        chk("idle_req", {31'd0, mem_req}, 32'd0);
        step();
`ifdef FETCH_PREFETCH_EN
        for (int k = 0; k < 2; k++) begin
            chk_fetch("stream", 1'b1, 32'(4 * k));
            if (k == 0) chk("stream_v0", {31'd0, id_valid}, 32'd0);
            else        chk_id("stream_id", 32'(4 * k), ins(32'(4 * (k - 1))));
            step();
        end
`else
        for (int k = 0; k < 2; k++) begin
            chk_fetch("stream", 1'b1, 32'(4 * k));
            chk("stream_v0", {31'd0, id_valid}, 32'd0);
            step();
            chk_fetch("stream_hold", 1'b0, 32'(4 * k + 4));
            chk_id("stream_id", 32'(4 * k + 4), ins(32'(4 * k)));
            step();
        end
`endif

        // Branch coincident with an ack at address 8
        chk_fetch("br_pre", 1'b1, 32'd8);
        branch_taken = 1'b1; branch_addr = 32'h0000_0103;
        step();
        branch_taken = 1'b0;
        chk_fetch("br_tgt", 1'b1, 32'h100);
        chk("br_flush", {31'd0, id_valid}, 32'd0);
        step();
        chk_id("br_data", 32'h104, ins(32'h100));

        // Redirect to 12 and stall the ack for five cycles
        branch_taken = 1'b1; branch_addr = 32'd12; mem_ack = 1'b0;
        step();
        branch_taken = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_fetch("ack_wait", 1'b1, 32'd12);
            chk("ack_wait_v", {31'd0, id_valid}, 32'd0);
            step();
        end
        chk_fetch("ack_end", 1'b1, 32'd12);
        mem_ack = 1'b1;
        step();
        chk_id("ack_push", 32'd16, ins(32'd12));
        chk("ack_next_addr", mem_addr, 32'd16);
`ifdef FETCH_PREFETCH_EN
        chk("ack_next_req", {31'd0, mem_req}, 32'd1);
`else
        chk("ack_next_req", {31'd0, mem_req}, 32'd0);
`endif

        // Address wrap at the top of the space
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        chk_fetch("wrap0", 1'b1, 32'hFFFF_FFFC);
        chk("wrap0_v", {31'd0, id_valid}, 32'd0);
        step();
        chk_id("wrap_id0", 32'd0, ins(32'hFFFF_FFFC));
        chk("wrap_addr1", mem_addr, 32'd0);
        step();
`ifndef FETCH_PREFETCH_EN
        chk_fetch("wrap1", 1'b1, 32'd0);
        step();
`endif
        chk_id("wrap_id1", 32'd4, ins(32'd0));

        // Reset mid-request abandons the fetch
        rst = 1'b0;
        step();
        chk_zero("rst2");
        rst = 1'b1; id_ready = 1'b0; mem_ack = 1'b1;
        chk("rel2_idle", {31'd0, mem_req}, 32'd0);
        step();
        chk_fetch("rel2", 1'b1, 32'd0);
        #3 rst = 1'b0;
        #1 chk_zero("rst_midreq");
        step();
        chk_zero("rst_held");
        rst = 1'b1;
        chk("rel3_idle", {31'd0, mem_req}, 32'd0);
        step();
        chk_fetch("rel3", 1'b1, 32'd0);
        chk("rel3_v", {31'd0, id_valid}, 32'd0);
        step();

        // Decode stall fills the queue, then drains in order
`ifdef FETCH_PREFETCH_EN
        chk_fetch("pf1", 1'b1, 32'd4);
        chk_id("pf1_id", 32'd4, ins(32'd0));
        step();
        chk_fetch("pf_hold", 1'b0, 32'd8);
        chk_id("pf_hold_id", 32'd4, ins(32'd0));
        step();
        chk_fetch("pf_hold2", 1'b0, 32'd8);
        id_ready = 1'b1;
        step();
        chk_fetch("pf_resume", 1'b1, 32'd8);
        chk_id("pf_pop2", 32'd8, ins(32'd4));
        id_ready = 1'b0;
        step(); step();
`else
        chk_fetch("pf1", 1'b0, 32'd4);
        chk_id("pf1_id", 32'd4, ins(32'd0));
        step();
        chk_fetch("pf_hold2", 1'b0, 32'd4);
        id_ready = 1'b1;
        step();
        chk_fetch("pf_resume", 1'b1, 32'd4);
        chk("pf_resume_v", {31'd0, id_valid}, 32'd0);
        id_ready = 1'b0;
        step(); step();
`endif
        chk("full_hold_req", {31'd0, mem_req}, 32'd0);
        chk("full_hold_v", {31'd0, id_valid}, 32'd1);

        // Asynchronous reset while the queue is full
        #3 rst = 1'b0;
        #1 chk_zero("rst_full");
        step();
        rst = 1'b1;
        step();
        chk_fetch("restart", 1'b1, 32'd0);
        chk("restart_v", {31'd0, id_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
